instr_mem_loader: RTL and testbench

Instruction memory and program loader: the responder side of the instruction-fetch port (`IInstr.slave`). After reset it receives a program as a byte stream from the UART receiver and writes it into a 2^ADDR_WIDTH-word instruction BRAM. It sends one acknowledge byte back through the UART transmitter and then serves fetch requests with one-cycle synchronous-read latency. Its `load_busy` output holds the core in reset until the program is resident.

---
 rtl/instr_mem_loader_if.sv | 9 +
 rtl/instr_mem_loader.sv | 131 +++++++++++++
 tb/tb_instr_mem_loader.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Instruction-fetch port between the core (master) and the instruction memory
// (slave): the core drives a word address, the memory returns the instruction.
interface instr_mem_loader_if;
  logic [31:0] addr;
  logic [31:0] instr;

  modport master (output addr, input instr);
  modport slave  (input addr, output instr);
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction BRAM with a UART program loader: takes a length-prefixed
// little-endian word stream, acknowledges it, then serves registered fetches.
module instr_mem_loader #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter logic [31:0] NOP        = 32'hf0000000,
  parameter logic [7:0]  ACK_BYTE   = 8'haa
) (
  input  logic                clock,
  input  logic                reset,
  instr_mem_loader_if.slave   instr_mem,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready,
  output logic                load_busy,
  output logic                load_done,
  output logic                load_error
);

  typedef enum logic [2:0] {S_LEN, S_LOAD, S_ACK, S_RUN, S_ERR} state_t;

  localparam int unsigned         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [32:0]         DEPTH_N  = 33'(DEPTH);
  localparam logic [ADDR_WIDTH:0] WPTR_ONE = 1;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt;
  logic [31:0]           len_q;
  logic [23:0]           word_q;
  logic [ADDR_WIDTH:0]   wptr;
  logic [31:0]           instr_q;
  logic [31:0]           mem [DEPTH];

  logic [31:0]           len_full;
  logic [31:0]           word_full;
  logic [ADDR_WIDTH:0]   wptr_next;
  logic                  last_byte;
  logic                  mem_we;

  // Bytes arrive least-significant first, so both assemblers shift in from the top.
  assign len_full  = {rx_data, len_q[31:8]};
  assign word_full = {rx_data, word_q};
  assign wptr_next = wptr + WPTR_ONE;
  assign last_byte = rx_valid && (byte_cnt == 2'd3);
  assign mem_we    = !reset && (state_q == S_LOAD) && last_byte;
  assign tx_data   = ACK_BYTE;

  assign instr_mem.instr = instr_q;

  // Upper fetch-address bits are architecturally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, instr_mem.addr[31:ADDR_WIDTH]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_LEN;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN: begin
        if (last_byte) begin
          if ({1'b0, len_full} > DEPTH_N) state_d = S_ERR;
          else if (len_full == 32'd0)     state_d = S_ACK;
          else                            state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (last_byte && (wptr_next == len_q[ADDR_WIDTH:0])) state_d = S_ACK;
      end
      S_ACK: begin
        if (tx_ready) state_d = S_RUN;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    tx_valid   = 1'b0;
    load_busy  = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state_q)
      S_ACK: tx_valid = 1'b1;
      S_RUN: begin
        load_busy = 1'b0;
        load_done = 1'b1;
      end
      S_ERR: load_error = 1'b1;
      default: ;
    endcase
  end

  // Length and word assembly; the byte counter wraps naturally from LEN into LOAD.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      len_q    <= 32'd0;
      word_q   <= 24'd0;
      wptr     <= '0;
    end else if (rx_valid) begin
      if (state_q == S_LEN) begin
        len_q    <= len_full;
        byte_cnt <= byte_cnt + 2'd1;
      end else if (state_q == S_LOAD) begin
        word_q   <= word_full[31:8];
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) wptr <= wptr_next;
      end
    end
  end

  // NOTE: the memory array has no reset so it maps onto block RAM; program
  // contents survive a reset by design.
  always_ff @(posedge clock) begin
    if (mem_we) mem[wptr[ADDR_WIDTH-1:0]] <= word_full;
  end

  // Writes happen only outside RUN, so the registered read never collides with one.
  always_ff @(posedge clock) begin
    if (reset)                  instr_q <= NOP;
    else if (state_q == S_RUN)  instr_q <= mem[instr_mem.addr[ADDR_WIDTH-1:0]];
    else                        instr_q <= NOP;
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: loads programs over the byte stream,
// checks acknowledge/status behaviour and compares fetches against a model.
module tb_instr_mem_loader;
  localparam logic [31:0] NOP = 32'hf0000000;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       load_busy;
  logic       load_done;
  logic       load_error;

  instr_mem_loader_if instr_bus ();

  instr_mem_loader dut (
    .clock      (clock),
    .reset      (reset),
    .instr_mem  (instr_bus.slave),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model [int];
  int model_wptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One byte per cycle; while loading, a random fetch address must still yield NOP.
  task automatic send_byte(input logic [7:0] b, input bit chk_nop);
    rx_valid = 1'b1;
    rx_data  = b;
    if (chk_nop) begin
      instr_bus.addr = $urandom;
      exp_q.push_back(NOP);
    end
    @(negedge clock);
    rx_valid = 1'b0;
    if (chk_nop) check("nop_while_loading", instr_bus.instr, exp_q.pop_front());
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    model[model_wptr] = w;
    model_wptr++;
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
    instr_bus.addr = a;
    exp_q.push_back(exp);
    @(negedge clock);
    check(tag, instr_bus.instr, exp_q.pop_front());
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clock);
    reset      = 1'b0;
    model_wptr = 0;
  endtask

  // Called right after the last stream byte: ack must already be offered.
  task automatic expect_ack_then_run();
    check("ack_valid", 32'(tx_valid), 32'd1);
    check("ack_data", 32'(tx_data), 32'haa);
    check("ack_busy", 32'(load_busy), 32'd1);
    tx_ready = 1'b1;
    @(negedge clock);
    check("run_tx_valid", 32'(tx_valid), 32'd0);
    check("run_busy", 32'(load_busy), 32'd0);
    check("run_done", 32'(load_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] len_word;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    instr_bus.addr = 32'd0;
    model_wptr = 0;
    @(negedge clock);
    check("rst_instr", instr_bus.instr, NOP);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'haa);
    check("rst_busy", 32'(load_busy), 32'd1);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_error", 32'(load_error), 32'd0);
    reset = 1'b0;

    // Normal two-word load and fetch.
    len_word = 32'd2;
    for (int i = 0; i < 4; i++) send_byte(len_word[8*i +: 8], 1'b1);
    send_word(32'h11223344);
    send_word(32'hdeadbeef);
    expect_ack_then_run();
    fetch("fetch_w0", 32'd0, model[0]);
    fetch("fetch_hi_bits", 32'h00008001, model[1]);
    for (int i = 0; i < 6; i++) fetch("fetch_toggle", 32'(i % 2), model[i % 2]);

    // Bytes in RUN are ignored.
    for (int i = 0; i < 8; i++) send_byte(8'h5a + 8'(i), 1'b0);
    check("run_rx_ignored_done", 32'(load_done), 32'd1);
    check("run_rx_ignored_txv", 32'(tx_valid), 32'd0);
    fetch("refetch_w0", 32'd0, model[0]);
    fetch("refetch_w1", 32'd1, model[1]);

    // Zero-length program with acknowledge backpressure.
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_tx_valid", 32'(tx_valid), 32'd1);
      check("bp_tx_data", 32'(tx_data), 32'haa);
      check("bp_busy", 32'(load_busy), 32'd1);
      send_byte(8'hc3, 1'b1);
    end
    expect_ack_then_run();
    fetch("zero_len_w0", 32'd0, model[0]);
    fetch("zero_len_w1", 32'd1, model[1]);

    // Oversize length: error, no acknowledge, input ignored.
    do_reset();
    len_word = 32'h00008001;
    for (int i = 0; i < 4; i++) send_byte(len_word[8*i +: 8], 1'b1);
    check("err_flag", 32'(load_error), 32'd1);
    check("err_busy", 32'(load_busy), 32'd1);
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(i), 1'b1);
      check("err_tx_valid", 32'(tx_valid), 32'd0);
      check("err_sticky", 32'(load_error), 32'd1);
    end
    check("err_done", 32'(load_done), 32'd0);

    // Reset mid-load, with a byte strobed during reset that must be dropped.
    do_reset();
    len_word = 32'd2;
    for (int i = 0; i < 4; i++) send_byte(len_word[8*i +: 8], 1'b1);
    send_byte(8'hbb, 1'b1);
    send_byte(8'hcc, 1'b1);
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h05;
    @(negedge clock);
    reset = 1'b0; rx_valid = 1'b0; model_wptr = 0;
    check("midrst_error", 32'(load_error), 32'd0);
    check("midrst_busy", 32'(load_busy), 32'd1);
    len_word = 32'd1;
    for (int i = 0; i < 4; i++) send_byte(len_word[8*i +: 8], 1'b1);
    send_word(32'h12345678);
    expect_ack_then_run();
    fetch("midrst_w0", 32'd0, model[0]);
    fetch("midrst_w1_kept", 32'd1, 32'hdeadbeef);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
